// File: rtl/addr_seq_pkg.sv
// Shared types for the address sequencer: FSM state encoding and mode constants.
// No logic, no latency.
// No flow control; pure definitions.
package addr_seq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_CONT   = 1'b1;

endpackage

// File: rtl/address_sequencer.sv
// Generates BASE, BASE+STRIDE, ... for DEPTH steps per pass, single-shot or continuous.
// add_o/busy/done are registered; each accepted OE advances add_o on the next edge.
// OE low stalls the sequence indefinitely; abort or reset discard it without a done pulse.
module address_sequencer
    import addr_seq_pkg::*;
#(
    parameter int                 ADDR_W = 3,
    parameter int                 DEPTH  = 4,
    parameter logic [ADDR_W-1:0]  STRIDE = ADDR_W'(1),
    parameter logic [ADDR_W-1:0]  BASE   = ADDR_W'(0)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              init,
    input  logic              OE,
    input  logic              mode,
    input  logic              abort,
    output logic [ADDR_W-1:0] add_o,
    output logic              busy,
    output logic              done
);

    // A single-step sequence still needs one counter bit.
    localparam int               CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_mode;
    logic [ADDR_W-1:0]   r_add;
    logic                r_busy;
    logic                r_done;

    logic                w_last;

    assign w_last = (r_cnt == LAST);

    // FSM, step counter, address register and status flags advance together.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mode  <= MODE_SINGLE;
            r_add   <= BASE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_add <= BASE;
                    r_cnt <= '0;
                    if (init && !abort) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_mode  <= mode;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_add   <= BASE;
                        r_cnt   <= '0;
                    end else if (OE) begin
                        if (w_last) begin
                            // Terminal step: rewind and flag completion of the pass.
                            r_cnt  <= '0;
                            r_add  <= BASE;
                            r_done <= 1'b1;
                            if (r_mode != MODE_CONT) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            r_add <= r_add + STRIDE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_add   <= BASE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign add_o = r_add;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: doc/address_sequencer.md
ADDRESS_SEQUENCER -- requirements
Module: address_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 3: width of the address output.
REQ-002 The block SHALL have parameter DEPTH, default 4: addresses per sequence; legal range 1..2**ADDR_W.
REQ-003 The block SHALL have parameter STRIDE, default 1: address increment per step, ADDR_W bits.
REQ-004 The block SHALL have parameter BASE, default 0: first address of every sequence, ADDR_W bits.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port init, input, 1 bit: start request, sampled high for one cycle.
REQ-008 The block SHALL have port OE, input, 1 bit: advance strobe; a high sample consumes the current address.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = single-shot, 1 = continuous; sampled only when init is accepted.
REQ-010 The block SHALL have port abort, input, 1 bit: terminate the sequence immediately.
REQ-011 The block SHALL have port add_o, output, ADDR_W bits: current address, registered.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last address of a pass is consumed.

Function
REQ-014 The block SHALL implement two states, IDLE and RUN, plus an internal step counter cnt (0..DEPTH-1) and a latched mode bit.
REQ-015 In IDLE the block SHALL hold add_o=BASE, cnt=0, busy=0 and ignore OE.
REQ-016 In IDLE, when init=1 and abort=0, the block SHALL enter RUN on the next edge, latch mode, and keep add_o=BASE; busy rises on that edge.
REQ-017 In RUN with OE=1 and cnt<DEPTH-1, the block SHALL set cnt<=cnt+1 and add_o<=add_o+STRIDE, modulo 2**ADDR_W (silent wrap).
REQ-018 In RUN with OE=1 and cnt==DEPTH-1, the block SHALL set cnt<=0, add_o<=BASE, and assert done for exactly the following cycle.
REQ-019 On that terminal step the block SHALL go to IDLE if latched mode=0, and remain in RUN if latched mode=1.
REQ-020 In RUN with OE=0, the block SHALL hold all state; there is no timeout.
REQ-021 In RUN, init SHALL be ignored; it neither restarts nor re-latches mode.
REQ-022 abort=1 in RUN SHALL force IDLE, add_o=BASE, cnt=0 on the next edge, with no done pulse; abort takes priority over OE.
REQ-023 abort=1 in IDLE SHALL take priority over init; the block stays in IDLE.
REQ-024 With DEPTH=1, every accepted OE in RUN SHALL be a terminal step; add_o stays BASE.
REQ-025 done SHALL never be high for two consecutive cycles unless two terminal steps occur on consecutive edges (DEPTH=1, continuous mode).

Reset
REQ-026 RST_N=0 sampled at a rising CLK edge SHALL force IDLE, add_o=BASE, cnt=0, mode latch=0, busy=0, done=0, overriding all other inputs.
REQ-027 Reset asserted mid-sequence SHALL discard the sequence with no done pulse; after release, the block SHALL require a fresh init.
REQ-028 All outputs SHALL be driven from registers; there SHALL be no initial-block dependence.

Structure
REQ-029 A shared package addr_seq_pkg SHALL hold the state enum (IDLE, RUN) and the mode constants (MODE_SINGLE=0, MODE_CONT=1).
REQ-030 The block SHALL be a single module with no sub-module; the counter and FSM are inline, and the counter width is clog2(DEPTH), minimum 1.

Verification (defaults unless stated)
REQ-031 The bench SHALL cover: reset, init pulse with mode=0, OE held high -> add_o 0,1,2,3,0; done high one cycle after the step 3->0; busy falls with done; IDLE thereafter.
REQ-032 The bench SHALL cover: mode=1, OE high for 10 cycles -> add_o 0,1,2,3,0,1,2,3,0,1,2; done after each 3->0 step; busy stays 1.
REQ-033 The bench SHALL cover: STRIDE=3, BASE=6, ADDR_W=3, DEPTH=4 -> add_o 6,1,4,7,6 (mod-8 wrap); single done pulse.
REQ-034 The bench SHALL cover: abort and OE both high at add_o=2 -> next cycle IDLE, add_o=0, no done; later init with abort=1 -> stays IDLE.
REQ-035 The bench SHALL cover: OE gapped (1,0,0,1,...) plus init asserted in RUN -> address advances only on OE=1 cycles; init has no effect.
REQ-036 The bench SHALL cover: RST_N=0 at add_o=2 -> next edge add_o=0, busy=0, done=0; OE alone after release -> no advance.
